// File: rtl/verificador_senha.sv
// Password checker for the bomb game.
//
// The player enters a 4-bit guess on SW and confirms it with the KEY_ENTER push
// button. Password A (4 bits) must be matched first, then password B (3 bits,
// SW[3] ignored). MAX_ERROS wrong guesses detonate the bomb.
//
// Build option: define DEBOUNCE_EN to filter the synchronized key with a
// DEBOUNCE_CICLOS-sample stability counter. Without it the synchronized key
// edge is used directly and no counter is built.
//
// Ports:
//   CLOCK_50         in   sole clock, rising edge
//   RESET_N          in   asynchronous active-low reset
//   ENABLE           in   game running; low returns an active game to idle
//   KEY_ENTER        in   raw push button, active-low, asynchronous
//   SW[3:0]          in   guess switches
//   A[3:0], B[2:0]   in   passwords, static during play
//   TENTATIVA[3:0]   out  guess latched at the accepted press
//   ENTER            out  one-cycle pulse per evaluated guess
//   ACERTOU_SENHA_A  out  password A solved
//   DESARMADA        out  bomb defused (terminal)
//   EXPLODIU         out  bomb detonated (terminal)
//   ERROS[1:0]       out  wrong guesses in the current game
module verificador_senha #(
  parameter int unsigned MAX_ERROS       = 3,
  parameter int unsigned DEBOUNCE_CICLOS = 500000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       ENABLE,
  input  logic       KEY_ENTER,
  input  logic [3:0] SW,
  input  logic [3:0] A,
  input  logic [2:0] B,
  output logic [3:0] TENTATIVA,
  output logic       ENTER,
  output logic       ACERTOU_SENHA_A,
  output logic       DESARMADA,
  output logic       EXPLODIU,
  output logic [1:0] ERROS
);

  localparam logic [1:0] MaxErr = 2'(MAX_ERROS);

  typedef enum logic [2:0] {
    StOcioso,
    StSenhaA,
    StSenhaB,
    StDesarmada,
    StExplodiu
  } state_e;

  // ---------------------------------------------------------------------------
  // Key conditioning: 2-flop synchronizer, optional debounce, falling-edge event
  // ---------------------------------------------------------------------------
  logic sync1_q, sync2_q;
  logic key_cond;
  logic key_prev_q;
  logic evt_q;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= KEY_ENTER;
      sync2_q <= sync1_q;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int unsigned CntW    = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CICLOS - 1);

  logic            key_stable_q;
  logic [CntW-1:0] deb_cnt_q;

  // The counter tracks how many consecutive samples disagree with the accepted
  // level; any sample agreeing with it restarts the count.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      key_stable_q <= 1'b1;
      deb_cnt_q    <= '0;
    end else if (sync2_q == key_stable_q) begin
      deb_cnt_q <= '0;
    end else if (deb_cnt_q == CntLast) begin
      key_stable_q <= sync2_q;
      deb_cnt_q    <= '0;
    end else begin
      deb_cnt_q <= deb_cnt_q + 1'b1;
    end
  end

  assign key_cond = key_stable_q;
`else
  logic unused_debounce_ciclos;
  assign unused_debounce_ciclos = ^DEBOUNCE_CICLOS;
  assign key_cond = sync2_q;
`endif

  // Registered one-cycle event on the 1->0 transition of the conditioned key.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      key_prev_q <= 1'b1;
      evt_q      <= 1'b0;
    end else begin
      key_prev_q <= key_cond;
      evt_q      <= key_prev_q & ~key_cond;
    end
  end

  // ---------------------------------------------------------------------------
  // Game FSM
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [3:0] tentativa_q, tentativa_d;
  logic       enter_q, enter_d;
  logic       acertou_q, acertou_d;
  logic [1:0] erros_q, erros_d;
  logic       desarmada_q, explodiu_q;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= StOcioso;
      tentativa_q <= '0;
      enter_q     <= 1'b0;
      acertou_q   <= 1'b0;
      erros_q     <= '0;
      desarmada_q <= 1'b0;
      explodiu_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tentativa_q <= tentativa_d;
      enter_q     <= enter_d;
      acertou_q   <= acertou_d;
      erros_q     <= erros_d;
      desarmada_q <= (state_d == StDesarmada);
      explodiu_q  <= (state_d == StExplodiu);
    end
  end

  // An accepted event latches the guess and raises ENTER for one cycle; the
  // evaluation happens at the end of that ENTER cycle so the hint stage sees
  // the pre-evaluation flags while ENTER is high. ENABLE low always wins.
  always_comb begin
    state_d     = state_q;
    tentativa_d = tentativa_q;
    enter_d     = 1'b0;
    acertou_d   = acertou_q;
    erros_d     = erros_q;

    unique case (state_q)
      StOcioso: begin
        if (ENABLE) begin
          state_d   = StSenhaA;
          erros_d   = '0;
          acertou_d = 1'b0;
        end
      end

      StSenhaA, StSenhaB: begin
        if (!ENABLE) begin
          state_d   = StOcioso;
          erros_d   = '0;
          acertou_d = 1'b0;
        end else if (enter_q) begin
          if ((state_q == StSenhaA) ? (tentativa_q == A) : (tentativa_q[2:0] == B)) begin
            if (state_q == StSenhaA) begin
              state_d   = StSenhaB;
              acertou_d = 1'b1;
            end else begin
              state_d = StDesarmada;
            end
          end else begin
            erros_d = erros_q + 2'd1;
            if (erros_d == MaxErr) begin
              state_d = StExplodiu;
            end
          end
        end else if (evt_q) begin
          tentativa_d = SW;
          enter_d     = 1'b1;
        end
      end

      StDesarmada, StExplodiu: begin
        // Terminal: only reset leaves.
      end

      default: begin
        state_d = StOcioso;
      end
    endcase
  end

  assign TENTATIVA       = tentativa_q;
  assign ENTER           = enter_q;
  assign ACERTOU_SENHA_A = acertou_q;
  assign DESARMADA       = desarmada_q;
  assign EXPLODIU        = explodiu_q;
  assign ERROS           = erros_q;

endmodule

// File: tb/tb_verificador_senha.sv
// Directed self-checking bench for verificador_senha (MAX_ERROS=3,
// DEBOUNCE_CICLOS=4). Works with or without DEBOUNCE_EN defined.
module tb_verificador_senha;

  localparam int unsigned Deb = 4;
`ifdef DEBOUNCE_EN
  localparam int Lat = 4 + Deb;  // key fall -> ENTER high, in clock edges
`else
  localparam int Lat = 4;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N;
  logic       ENABLE;
  logic       KEY_ENTER;
  logic [3:0] SW;
  logic [3:0] A;
  logic [2:0] B;
  logic [3:0] TENTATIVA;
  logic       ENTER;
  logic       ACERTOU_SENHA_A;
  logic       DESARMADA;
  logic       EXPLODIU;
  logic [1:0] ERROS;

  int n_checks = 0;
  int n_fail   = 0;
  int enter_cnt = 0;
  int snap;
  int first_k;
  logic       acertou_in_pulse;
  logic [3:0] tent_in_pulse;

  verificador_senha #(
    .MAX_ERROS      (3),
    .DEBOUNCE_CICLOS(Deb)
  ) dut (
    .CLOCK_50       (CLOCK_50),
    .RESET_N        (RESET_N),
    .ENABLE         (ENABLE),
    .KEY_ENTER      (KEY_ENTER),
    .SW             (SW),
    .A              (A),
    .B              (B),
    .TENTATIVA      (TENTATIVA),
    .ENTER          (ENTER),
    .ACERTOU_SENHA_A(ACERTOU_SENHA_A),
    .DESARMADA      (DESARMADA),
    .EXPLODIU       (EXPLODIU),
    .ERROS          (ERROS)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Count ENTER high cycles, sampled mid-cycle.
  always @(negedge CLOCK_50) begin
    if (ENTER === 1'b1) enter_cnt <= enter_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  // Clean press: hold long enough to be accepted and evaluated, then release.
  task automatic press(input logic [3:0] sw);
    SW = sw;
    @(posedge CLOCK_50);
    #1 KEY_ENTER = 1'b0;
    cycles(Lat + 3);
    KEY_ENTER = 1'b1;
    cycles(Lat + 3);
  endtask

  task automatic do_reset(input logic en);
    RESET_N   = 1'b0;
    KEY_ENTER = 1'b1;
    ENABLE    = en;
    cycles(3);
    RESET_N = 1'b1;
    cycles(Lat + 3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    A = 4'b1010;
    B = 3'b101;
    SW = 4'b0000;
    KEY_ENTER = 1'b1;
    ENABLE = 1'b0;
    RESET_N = 1'b0;
    cycles(3);
    // Reset state
    check("rst_tentativa", TENTATIVA, 4'h0);
    check("rst_enter", ENTER, 1'b0);
    check("rst_acertou", ACERTOU_SENHA_A, 1'b0);
    check("rst_desarmada", DESARMADA, 1'b0);
    check("rst_explodiu", EXPLODIU, 1'b0);
    check("rst_erros", ERROS, 2'd0);
    RESET_N = 1'b1;
    cycles(Lat + 3);

    // Event while idle is ignored
    snap = enter_cnt;
    press(4'b1010);
    check("idle_no_enter", enter_cnt - snap, 0);
    check("idle_no_latch", TENTATIVA, 4'h0);

    // Correct A: latency, pre-evaluation flag during pulse, single event on hold
    ENABLE = 1'b1;
    cycles(2);
    snap = enter_cnt;
    SW = 4'b1010;
    @(posedge CLOCK_50);
    #1 KEY_ENTER = 1'b0;
    first_k = 0;
    acertou_in_pulse = 1'b1;
    tent_in_pulse = 4'h0;
    for (int k = 1; k <= Lat + 2; k++) begin
      cycles(1);
      if (ENTER && first_k == 0) begin
        first_k = k;
        acertou_in_pulse = ACERTOU_SENHA_A;
        tent_in_pulse = TENTATIVA;
      end
    end
    check("enter_latency", first_k, Lat);
    check("acertou_during_enter", acertou_in_pulse, 1'b0);
    check("tentativa_a", tent_in_pulse, 4'b1010);
    check("acertou_after", ACERTOU_SENHA_A, 1'b1);
    cycles(20);
    KEY_ENTER = 1'b1;
    cycles(Lat + 3);
    check("hold_one_enter", enter_cnt - snap, 1);

    // Correct B defuses; terminal ignores ENABLE and presses
    press(4'b0101);
    check("defused", DESARMADA, 1'b1);
    check("defused_erros", ERROS, 2'd0);
    check("defused_not_exploded", EXPLODIU, 1'b0);
    ENABLE = 1'b0;
    cycles(3);
    snap = enter_cnt;
    press(4'b0000);
    check("defused_terminal", DESARMADA, 1'b1);
    check("defused_acertou_kept", ACERTOU_SENHA_A, 1'b1);
    check("defused_no_enter", enter_cnt - snap, 0);

    // Three wrong guesses explode; fourth ignored
    do_reset(1'b1);
    check("rst2_desarmada", DESARMADA, 1'b0);
    press(4'b0000);
    check("erros_1", ERROS, 2'd1);
    press(4'b0000);
    check("erros_2", ERROS, 2'd2);
    check("not_yet_exploded", EXPLODIU, 1'b0);
    press(4'b0000);
    check("exploded", EXPLODIU, 1'b1);
    check("exploded_erros", ERROS, 2'd3);
    check("exploded_not_defused", DESARMADA, 1'b0);
    snap = enter_cnt;
    press(4'b0000);
    check("exploded_no_enter", enter_cnt - snap, 0);
    check("exploded_erros_hold", ERROS, 2'd3);
    check("exploded_hold", EXPLODIU, 1'b1);

    // Wrong in B counts; SW[3] ignored for B
    do_reset(1'b1);
    press(4'b1010);
    press(4'b0000);
    check("b_wrong_erros", ERROS, 2'd1);
    check("b_wrong_acertou", ACERTOU_SENHA_A, 1'b1);
    press(4'b1101);
    check("b_sw3_ignored", DESARMADA, 1'b1);

    // ENABLE dropped in the event cycle with ERROS=2
    do_reset(1'b1);
    press(4'b0000);
    press(4'b0000);
    check("pre_drop_erros", ERROS, 2'd2);
    snap = enter_cnt;
    SW = 4'b0000;
    @(posedge CLOCK_50);
    #1 KEY_ENTER = 1'b0;
    cycles(Lat - 1);
    ENABLE = 1'b0;
    cycles(1);
    check("drop_erros_clear", ERROS, 2'd0);
    cycles(3);
    check("drop_no_enter", enter_cnt - snap, 0);
    check("drop_not_exploded", EXPLODIU, 1'b0);
    KEY_ENTER = 1'b1;
    cycles(Lat + 3);
    ENABLE = 1'b1;
    cycles(2);
    press(4'b0000);
    check("drop_restart_erros", ERROS, 2'd1);

    // Reset during ENTER pulse in SENHA_B
    do_reset(1'b1);
    press(4'b1010);
    snap = enter_cnt;
    SW = 4'b0101;
    @(posedge CLOCK_50);
    #1 KEY_ENTER = 1'b0;
    cycles(Lat);
    check("pulse_before_reset", ENTER, 1'b1);
    #2 RESET_N = 1'b0;
    #1;
    check("async_enter", ENTER, 1'b0);
    check("async_acertou", ACERTOU_SENHA_A, 1'b0);
    check("async_tentativa", TENTATIVA, 4'h0);
    check("async_desarmada", DESARMADA, 1'b0);
    KEY_ENTER = 1'b1;
    cycles(2);
    RESET_N = 1'b1;
    cycles(Lat + 3);
    check("reset_pulse_dropped", enter_cnt - snap, 0);
    check("post_reset_not_defused", DESARMADA, 1'b0);
    press(4'b1010);
    check("post_reset_senha_a", ACERTOU_SENHA_A, 1'b1);
    press(4'b0000);
    check("post_reset_b_wrong", ERROS, 2'd1);

`ifdef DEBOUNCE_EN
    // Bouncing key: six 2-cycle toggles, then held low -> one event
    snap = enter_cnt;
    SW = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      KEY_ENTER = ~KEY_ENTER;
      cycles(2);
    end
    KEY_ENTER = 1'b0;
    cycles(100);
    KEY_ENTER = 1'b1;
    cycles(Lat + 3);
    check("bounce_one_enter", enter_cnt - snap, 1);
    check("bounce_erros", ERROS, 2'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/verificador_senha.md
VERIFICADOR_SENHA -- requirements
Module: verificador_senha

Interface
REQ-001 Parameter MAX_ERROS, default 3, wrong guesses that detonate the bomb; legal range 1..3.
REQ-002 Parameter DEBOUNCE_CICLOS, default 500000, consecutive stable cycles required to accept a key level (10 ms at 50 MHz).
REQ-003 CLOCK_50  in  1  sole clock; all state changes on its rising edge.
REQ-004 RESET_N  in  1  reset, asynchronous, active-low.
REQ-005 ENABLE  in  1  game running; low forces the checker idle.
REQ-006 KEY_ENTER  in  1  raw push button, active-low (0 = pressed), asynchronous to CLOCK_50.
REQ-007 SW  in  4  guess switches.
REQ-008 A  in  4  password A; B  in  3  password B; both static during play.
REQ-009 TENTATIVA  out  4  guess latched at the accepted press.
REQ-010 ENTER  out  1  one-cycle high pulse per evaluated guess, feeds the hint stage.
REQ-011 ACERTOU_SENHA_A  out  1  password A solved.
REQ-012 DESARMADA  out  1  bomb defused; EXPLODIU  out  1  bomb detonated.
REQ-013 ERROS  out  2  count of wrong guesses in the current game.

Function
REQ-014 KEY_ENTER SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 A press event SHALL be one cycle, on the 1->0 transition of the conditioned key; holding the key SHALL yield exactly one event.
REQ-016 FSM states: OCIOSO, SENHA_A, SENHA_B, DESARMADA, EXPLODIU.
REQ-017 OCIOSO -> SENHA_A when ENABLE=1; ERROS and ACERTOU_SENHA_A cleared.
REQ-018 In SENHA_A, an event with SW==A SHALL go to SENHA_B; SW!=A SHALL increment ERROS.
REQ-019 In SENHA_B, an event with SW[2:0]==B SHALL go to DESARMADA (SW[3] ignored); mismatch SHALL increment ERROS.
REQ-020 A wrong guess that makes ERROS equal MAX_ERROS SHALL go to EXPLODIU; ERROS saturates at MAX_ERROS.
REQ-021 DESARMADA and EXPLODIU are terminal: only RESET_N leaves them; ENABLE ignored there.
REQ-022 ENABLE=0 in SENHA_A or SENHA_B SHALL return to OCIOSO next edge, clearing ERROS and ACERTOU_SENHA_A.
REQ-023 Events in OCIOSO, DESARMADA or EXPLODIU SHALL be ignored: no latch, no ENTER pulse.
REQ-024 Timing for event in cycle N: TENTATIVA<=SW at end of N; ENTER=1 during N+1 only; state, ERROS, ACERTOU_SENHA_A, DESARMADA, EXPLODIU update at end of N+1, so the hint stage samples pre-evaluation flags at the ENTER rising edge.
REQ-025 ENABLE falling in N or N+1 SHALL win: no ENTER pulse (or pulse truncated to none), no evaluation, OCIOSO.
REQ-026 ACERTOU_SENHA_A SHALL stay 1 from SENHA_B entry through DESARMADA or EXPLODIU.
REQ-027 DESARMADA=1 only in state DESARMADA; EXPLODIU=1 only in state EXPLODIU; never both.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 RESET_N=0 SHALL immediately force OCIOSO, TENTATIVA=0, ENTER=0, ACERTOU_SENHA_A=0, DESARMADA=0, EXPLODIU=0, ERROS=0, synchronizer flops=1 (released), debounce counter=0, pending evaluation dropped.
REQ-030 Reset mid-pulse SHALL terminate ENTER at once; first event after release requires a fresh press.

Configuration
REQ-031 Macro DEBOUNCE_EN defined: synchronized key SHALL be accepted only after DEBOUNCE_CICLOS consecutive equal samples; counter restarts on any change.
REQ-032 DEBOUNCE_EN undefined: event is the edge of the synchronized key directly; DEBOUNCE_CICLOS unused; no counter logic synthesized.

Verification (DEBOUNCE_EN defined, DEBOUNCE_CICLOS=4, MAX_ERROS=3)
REQ-033 A=4'b1010, B=3'b101, ENABLE=1, SW=1010, press -> TENTATIVA=1010, one ENTER pulse with ACERTOU_SENHA_A=0 during it, then ACERTOU_SENHA_A=1; SW=0101, press -> DESARMADA=1, ERROS=0.
REQ-034 Three presses with SW=0000 -> ERROS 1,2, then EXPLODIU=1, ERROS=3; fourth press -> no ENTER, outputs unchanged.
REQ-035 KEY_ENTER toggling every 2 cycles for 12 cycles then held low 100 cycles -> exactly one ENTER pulse.
REQ-036 ENABLE dropped in the event cycle with ERROS=2 -> no ENTER, state OCIOSO, ERROS=0, EXPLODIU=0.
REQ-037 RESET_N pulsed low during ENTER pulse in SENHA_B -> all outputs 0 asynchronously, SENHA_A re-entered after release with ENABLE=1.
REQ-038 DEBOUNCE_EN undefined, single clean press -> ENTER high exactly 4 cycles after KEY_ENTER falls (2 sync + event + pulse).
